riscv_soc_top: RTL and testbench

- Top-level SoC wrapper around the byte-bus RV32I core (external module `cpu`, existing interface).
- Provides the following around the core:
  - reset conditioning;
  - on-chip byte-addressed RAM;
  - memory-mapped UART (TX/RX);
  - halt register driving a status LED.
- With SIM=1 the UART is bypassed: characters are printed by the simulator and the halt register ends simulation.

---
 rtl/riscv_soc_top_if.sv | 38 +++
 rtl/riscv_soc_top.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_riscv_soc_top.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_soc_top_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_soc_top_if
// Description : Byte-wide bus between the RV32I core and the SoC wrapper.
//               The core is the master: it issues one byte address per
//               cycle, with an optional write strobe. The SoC is the slave:
//               it returns read data one cycle later and also supplies the
//               conditioned reset, the ready strobe and the IO back-pressure
//               flag.
// Signals     : mem_a[31:0]     byte address           (master -> slave)
//               mem_dout[7:0]   write data             (master -> slave)
//               mem_wr          write strobe           (master -> slave)
//               mem_din[7:0]    read data, 1-cycle lag (slave -> master)
//               io_buffer_full  UART TX FIFO near full (slave -> master)
//               rst_in          conditioned reset      (slave -> master)
//               rdy_in          core ready/enable      (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_soc_top_if;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        rst_in;
   logic        rdy_in;

   modport master (
      output mem_a, mem_dout, mem_wr,
      input  mem_din, io_buffer_full, rst_in, rdy_in
   );

   modport slave (
      input  mem_a, mem_dout, mem_wr,
      output mem_din, io_buffer_full, rst_in, rdy_in
   );
endinterface
`default_nettype wire

// File: rtl/riscv_soc_top.sv
`default_nettype none
// ============================================================================
// Module      : riscv_soc_top
// Description : SoC wrapper for the byte-bus RV32I core. Provides a two-flop
//               reset conditioner, byte-addressed on-chip RAM, a memory-mapped
//               UART (TX with FIFO, RX with a one-byte holding register) and a
//               halt register that lights the status LED.
//               The core attaches via the master modport of riscv_soc_top_if.
// Ports       : EXCLK   system clock, rising edge
//               btnC    synchronous active-high reset request
//               Tx      UART serial out (idles 1)
//               Rx      UART serial in  (idles 1)
//               led     1 once the program has halted
//               bus     core bus, slave side
// Memory map  : mem_a[17:16] == 2'b11 -> IO space, everything else -> RAM
//               0x30000 W: push UART TX byte   R: RX byte (clears valid) or 0
//               0x30004 W: halt                R: 0
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_soc_top #(
   parameter int SIM            = 0,
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int CLKS_PER_BIT   = 868,
   parameter int TX_FIFO_DEPTH  = 8
) (
   input  wire            EXCLK,
   input  wire            btnC,
   output logic           Tx,
   input  wire            Rx,
   output logic           led,
   riscv_soc_top_if.slave bus
);

   localparam int             c_CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
   localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);
   localparam int             c_PW        = $clog2(TX_FIFO_DEPTH);
   localparam int             c_CNTW      = c_PW + 1;
   localparam logic [c_CNTW-1:0] c_DEPTH  = c_CNTW'(TX_FIFO_DEPTH);
   localparam logic [c_CNTW-1:0] c_NEAR_FULL = c_CNTW'(TX_FIFO_DEPTH - 1);
   // In the simulation build TX bytes are printed instead of serialised.
   localparam bit             c_SERIAL    = (SIM == 0);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_START = 2'd1;
   localparam logic [1:0] c_ST_DATA  = 2'd2;
   localparam logic [1:0] c_ST_STOP  = 2'd3;

   // ------------------------------------------------------------------ reset
   logic r_rst_meta;
   logic r_rst;

   always_ff @(posedge EXCLK) begin
      r_rst_meta <= btnC;
      r_rst      <= r_rst_meta;
   end

   assign bus.rst_in = r_rst;
   assign bus.rdy_in = 1'b1;

   // ----------------------------------------------------------------- decode
   logic        w_io_sel;
   logic [15:0] w_io_off;
   logic        w_uart_wr;
   logic        w_uart_rd;
   logic        w_halt_wr;
   logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;
   logic        w_unused_bits;

   assign w_io_sel   = (bus.mem_a[17:16] == 2'b11);
   assign w_io_off   = bus.mem_a[15:0];
   assign w_uart_wr  = w_io_sel &  bus.mem_wr & (w_io_off == 16'h0000);
   assign w_uart_rd  = w_io_sel & ~bus.mem_wr & (w_io_off == 16'h0000);
   assign w_halt_wr  = w_io_sel &  bus.mem_wr & (w_io_off == 16'h0004);
   assign w_ram_addr = bus.mem_a[RAM_ADDR_WIDTH-1:0];
   assign w_unused_bits = ^bus.mem_a[31:18];

   // -------------------------------------------------------------------- RAM
   logic [7:0] r_ram [0:2**RAM_ADDR_WIDTH-1];
   logic [7:0] r_ram_q;

   always_ff @(posedge EXCLK) begin
      if (bus.mem_wr && !w_io_sel)
         r_ram[w_ram_addr] <= bus.mem_dout;
      r_ram_q <= r_ram[w_ram_addr];
   end

   // ------------------------------------------------------- RX holding reg
   logic       r_rx_valid;
   logic [7:0] r_rx_data;
   logic       w_rx_done;

   // Read-data mux follows the select of the previous cycle so that RAM and
   // IO both present data with the same one-cycle latency.
   logic       r_io_sel_q;
   logic [7:0] r_io_q;

   always_ff @(posedge EXCLK) begin
      if (r_rst) begin
         r_io_sel_q <= 1'b0;
         r_io_q     <= 8'h00;
      end else begin
         r_io_sel_q <= w_io_sel;
         r_io_q     <= (w_uart_rd && r_rx_valid) ? r_rx_data : 8'h00;
      end
   end

   assign bus.mem_din = r_io_sel_q ? r_io_q : r_ram_q;

   // ------------------------------------------------------------------- halt
   logic r_halt;

   always_ff @(posedge EXCLK) begin
      if (r_rst)
         r_halt <= 1'b0;
      else if (w_halt_wr)
         r_halt <= 1'b1;
   end

   assign led = r_halt;

   // ---------------------------------------------------------------- TX FIFO
   logic [7:0]        r_fifo [TX_FIFO_DEPTH];
   logic [c_PW-1:0]   r_wr_ptr;
   logic [c_PW-1:0]   r_rd_ptr;
   logic [c_CNTW-1:0] r_count;
   logic              w_tx_push;
   logic              w_tx_pop;
   logic [1:0]        r_tx_state;

   assign w_tx_push = c_SERIAL && w_uart_wr && (r_count != c_DEPTH);
   assign w_tx_pop  = (r_tx_state == c_ST_IDLE) && (r_count != '0);

   always_ff @(posedge EXCLK) begin
      if (w_tx_push)
         r_fifo[r_wr_ptr] <= bus.mem_dout;
   end

   // Pointers are exactly log2(depth) wide, so they wrap on their own.
   always_ff @(posedge EXCLK) begin
      if (r_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_tx_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_tx_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.io_buffer_full = (r_count >= c_NEAR_FULL);

   // ---------------------------------------------------------------- UART TX
   logic [1:0]      w_tx_next;
   logic [c_CW-1:0] r_tx_clk;
   logic [2:0]      r_tx_bit;
   logic [7:0]      r_tx_byte;
   logic            w_tx_tick;
   logic            w_tx_line;

   assign w_tx_tick = (r_tx_clk == c_BIT_LAST);

   always_ff @(posedge EXCLK) begin
      if (r_rst)
         r_tx_state <= c_ST_IDLE;
      else
         r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         c_ST_IDLE:  if (w_tx_pop)  w_tx_next = c_ST_START;
         c_ST_START: if (w_tx_tick) w_tx_next = c_ST_DATA;
         c_ST_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = c_ST_STOP;
         c_ST_STOP:  if (w_tx_tick) w_tx_next = c_ST_IDLE;
         default:    w_tx_next = c_ST_IDLE;
      endcase
   end

   // Bit index wraps back to 0 after the eighth data bit, ready for the next
   // frame.
   always_ff @(posedge EXCLK) begin
      if (r_rst) begin
         r_tx_clk <= '0;
         r_tx_bit <= '0;
      end else begin
         if (r_tx_state == c_ST_IDLE || w_tx_tick)
            r_tx_clk <= '0;
         else
            r_tx_clk <= r_tx_clk + 1'b1;
         if (r_tx_state == c_ST_DATA && w_tx_tick)
            r_tx_bit <= r_tx_bit + 1'b1;
      end
      if (w_tx_pop)
         r_tx_byte <= r_fifo[r_rd_ptr];
   end

   always_comb begin
      w_tx_line = 1'b1;
      case (r_tx_state)
         c_ST_START: w_tx_line = 1'b0;
         c_ST_DATA:  w_tx_line = r_tx_byte[r_tx_bit];
         default:    w_tx_line = 1'b1;
      endcase
   end

   assign Tx = w_tx_line;

   // ---------------------------------------------------------------- UART RX
   logic            r_rx_s1;
   logic            r_rx_s2;
   logic            r_rx_s3;
   logic            w_rx_fall;
   logic [1:0]      r_rx_state;
   logic [1:0]      w_rx_next;
   logic [c_CW-1:0] r_rx_clk;
   logic [2:0]      r_rx_bit;
   logic [7:0]      r_rx_shift;
   logic            w_rx_half;
   logic            w_rx_tick;
   logic            w_rx_clr;

   always_ff @(posedge EXCLK) begin
      if (r_rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_s3 <= 1'b1;
      end else begin
         r_rx_s1 <= Rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
      end
   end

   assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
   assign w_rx_half = (r_rx_clk == c_HALF_LAST);
   assign w_rx_tick = (r_rx_clk == c_BIT_LAST);

   always_ff @(posedge EXCLK) begin
      if (r_rst)
         r_rx_state <= c_ST_IDLE;
      else
         r_rx_state <= w_rx_next;
   end

   // START waits half a bit and re-checks the line (glitch rejection); from
   // then on every full bit period lands in the middle of the next bit.
   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         c_ST_IDLE:  if (w_rx_fall) w_rx_next = c_ST_START;
         c_ST_START: if (w_rx_half) w_rx_next = r_rx_s2 ? c_ST_IDLE : c_ST_DATA;
         c_ST_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = c_ST_STOP;
         c_ST_STOP:  if (w_rx_tick) w_rx_next = c_ST_IDLE;
         default:    w_rx_next = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_rx_clr  = (r_rx_state == c_ST_IDLE)
               || (r_rx_state == c_ST_START && w_rx_half)
               || (r_rx_state != c_ST_START && w_rx_tick);
      w_rx_done = (r_rx_state == c_ST_STOP) && w_rx_tick && r_rx_s2;
   end

   always_ff @(posedge EXCLK) begin
      if (r_rst) begin
         r_rx_clk   <= '0;
         r_rx_bit   <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_clk <= w_rx_clr ? '0 : r_rx_clk + 1'b1;
         if (r_rx_state == c_ST_DATA && w_rx_tick)
            r_rx_bit <= r_rx_bit + 1'b1;
         // A freshly received byte takes precedence over a read clearing it.
         if (w_rx_done)
            r_rx_valid <= 1'b1;
         else if (w_uart_rd)
            r_rx_valid <= 1'b0;
      end
      if (r_rx_state == c_ST_DATA && w_rx_tick)
         r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
      if (w_rx_done)
         r_rx_data <= r_rx_shift;
   end

   // ------------------------------------------------------ simulation build
   generate
      if (SIM != 0) begin : g_sim
         logic [63:0] r_cycles;

         always_ff @(posedge EXCLK) begin
            if (r_rst)
               r_cycles <= '0;
            else
               r_cycles <= r_cycles + 64'd1;
            if (!r_rst && w_uart_wr)
               $write("%c", bus.mem_dout);
            if (!r_rst && w_halt_wr) begin
               $display("halt after %0d cycles", r_cycles);
               $finish;
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_riscv_soc_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_soc_top
// Description : Self-checking bench for riscv_soc_top. The bench plays the
//               core on the bus interface, keeps a byte-array RAM model, an
//               RX holding-register model and a serial-line decoder on Tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_soc_top;
   localparam int AW  = 12;
   localparam int CPB = 4;
   localparam int DEP = 8;
   localparam logic [31:0] A_UART = 32'h0003_0000;
   localparam logic [31:0] A_HALT = 32'h0003_0004;

   logic clk  = 1'b0;
   logic btnC = 1'b1;
   logic Rx   = 1'b1;
   logic Tx;
   logic led;

   riscv_soc_top_if bus ();

   riscv_soc_top #(
      .SIM            (0),
      .RAM_ADDR_WIDTH (AW),
      .CLKS_PER_BIT   (CPB),
      .TX_FIFO_DEPTH  (DEP)
   ) dut (
      .EXCLK (clk),
      .btnC  (btnC),
      .Tx    (Tx),
      .Rx    (Rx),
      .led   (led),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] ram_m [2**AW];
   logic [8:0] txq [$];      // {framing_error, byte} decoded from Tx
   bit         mon_en = 1'b0;

   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [7:0]  d;
      logic [7:0]  e;
   } vec_t;

   vec_t tv [13];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
      bus.mem_a    = a;
      bus.mem_dout = d;
      bus.mem_wr   = 1'b1;
      cyc();
      bus.mem_wr   = 1'b0;
      bus.mem_a    = 32'h0;
      if (a[17:16] != 2'b11)
         ram_m[a[AW-1:0]] = d;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
      bus.mem_a  = a;
      bus.mem_wr = 1'b0;
      cyc();
      d          = bus.mem_din;
      bus.mem_a  = 32'h0;
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop);
      Rx = 1'b0;
      repeat (CPB) cyc();
      for (int i = 0; i < 8; i++) begin
         Rx = b[i];
         repeat (CPB) cyc();
      end
      Rx = stop;
      repeat (CPB) cyc();
      Rx = 1'b1;
      repeat (CPB) cyc();
   endtask

   task automatic wait_q(input int n, input int max_cycles);
      int c = 0;
      while (txq.size() < n && c < max_cycles) begin
         cyc();
         c++;
      end
      chk("txq_wait", (txq.size() >= n), 1);
   endtask

   // Serial decoder: every bit must hold for exactly CPB samples.
   initial begin : mon
      logic [7:0] b;
      logic       bad;
      logic       first;
      forever begin
         @(posedge clk);
         #2;
         if (mon_en && Tx === 1'b0) begin
            bad = 1'b0;
            b   = 8'h00;
            for (int k = 0; k < 10; k++) begin
               for (int s = 0; s < CPB; s++) begin
                  if (k != 0 || s != 0) begin
                     @(posedge clk);
                     #2;
                  end
                  if (s == 0) first = Tx;
                  else if (Tx !== first) bad = 1'b1;
               end
               if (k == 0 && first !== 1'b0) bad = 1'b1;
               if (k >= 1 && k <= 8) b[k-1] = first;
               if (k == 9 && first !== 1'b1) bad = 1'b1;
            end
            if (mon_en) txq.push_back({bad, b});
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] rd;
      logic [9:0] fr;
      logic [7:0] fb [10];
      logic [8:0] ent;
      int         w;
      int         match;
      int         lo;
      logic [31:0] a;
      logic [7:0] rb;
      logic       st;

      bus.mem_a    = 32'h0;
      bus.mem_dout = 8'h00;
      bus.mem_wr   = 1'b0;

      // power-up reset, then plant a known byte at address 0
      repeat (5) cyc();
      btnC = 1'b0;
      repeat (3) cyc();
      chk("rst_in_low", bus.rst_in, 0);
      bus_write(32'h0, 8'h3C);

      // 25-cycle reset: outputs idle, RAM contents kept
      btnC = 1'b1;
      for (int i = 0; i < 25; i++) begin
         cyc();
         chk($sformatf("rst_tx_%0d", i), Tx, 1);
         chk($sformatf("rst_led_%0d", i), led, 0);
      end
      chk("rst_in_high", bus.rst_in, 1);
      chk("rdy_in", bus.rdy_in, 1);
      chk("rst_full", bus.io_buffer_full, 0);
      btnC = 1'b0;
      repeat (2) cyc();
      chk("rst_in_release", bus.rst_in, 0);
      cyc();
      chk("fetch_ram0", bus.mem_din, 8'h3C);
      mon_en = 1'b1;

      // table-driven bus vectors (RAM aliasing uses AW=12)
      tv[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
      tv[1]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
      tv[2]  = '{1'b1, 32'h0000_0FFF, 8'h5C, 8'h00};
      tv[3]  = '{1'b0, 32'h0000_0FFF, 8'h00, 8'h5C};
      tv[4]  = '{1'b1, 32'h0000_1010, 8'h3D, 8'h00};
      tv[5]  = '{1'b0, 32'h0000_0010, 8'h00, 8'h3D};
      tv[6]  = '{1'b0, A_UART,        8'h00, 8'h00};
      tv[7]  = '{1'b0, A_HALT,        8'h00, 8'h00};
      tv[8]  = '{1'b1, 32'h0003_0008, 8'hFF, 8'h00};
      tv[9]  = '{1'b0, 32'h0003_0008, 8'h00, 8'h00};
      tv[10] = '{1'b0, 32'h0002_0010, 8'h00, 8'h3D};
      tv[11] = '{1'b1, 32'h0001_FFFF, 8'h77, 8'h00};
      tv[12] = '{1'b0, 32'h0000_0FFF, 8'h00, 8'h77};
      for (int i = 0; i < 13; i++) begin
         if (tv[i].wr) bus_write(tv[i].a, tv[i].d);
         else begin
            bus_read(tv[i].a, rd);
            chk($sformatf("vec_%0d", i), rd, tv[i].e);
         end
      end
      chk("led_after_vectors", led, 0);

      // randomized RAM traffic over an aliased 64-byte window
      for (int i = 0; i < 64; i++) bus_write(32'(i), 8'($urandom));
      for (int i = 0; i < 200; i++) begin
         lo = $urandom_range(0, 63);
         a  = (32'($urandom_range(0, 2)) << 16) | (32'($urandom_range(0, 15)) << 12) | 32'(lo);
         if ($urandom_range(0, 1) == 1) bus_write(a, 8'($urandom));
         else begin
            bus_read(a, rd);
            chk($sformatf("rand_rd_%0h", a), rd, ram_m[a[AW-1:0]]);
         end
      end

      // single byte 0x41: exact serial waveform
      bus_write(A_UART, 8'h41);
      w = 0;
      while (Tx !== 1'b0 && w < 6) begin
         cyc();
         w++;
      end
      chk("tx41_start_seen", Tx, 0);
      fr = {1'b1, 8'h41, 1'b0};
      for (int k = 0; k < 10; k++) begin
         match = 0;
         for (int s = 0; s < CPB; s++) begin
            if (k != 0 || s != 0) cyc();
            if (Tx === fr[k]) match++;
         end
         chk($sformatf("tx41_bit%0d_cycles", k), match, CPB);
      end
      cyc();
      chk("tx41_idle_after", Tx, 1);
      wait_q(1, 20);
      if (txq.size() > 0) begin
         ent = txq.pop_front();
         chk("tx41_decoded", ent, {1'b0, 8'h41});
      end

      // back-to-back writes: one byte goes straight to the shifter, so the
      // FIFO holds 7 after 8 writes; capacity is 8 + 1 and the 10th drops
      for (int i = 0; i < 10; i++) begin
         fb[i] = 8'($urandom);
         bus_write(A_UART, fb[i]);
         chk($sformatf("full_after_%0d", i + 1), bus.io_buffer_full, (i >= 7));
      end
      wait_q(9, 9 * (10 * CPB + 4) + 40);
      repeat (60) cyc();
      chk("fifo_tx_count", txq.size(), 9);
      for (int i = 0; i < 9; i++) begin
         if (txq.size() > 0) begin
            ent = txq.pop_front();
            chk($sformatf("fifo_tx_%0d", i), ent, {1'b0, fb[i]});
         end
      end
      chk("full_drained", bus.io_buffer_full, 0);

      // UART RX
      uart_send(8'h5A, 1'b1);
      bus_read(A_UART, rd);
      chk("rx_5a", rd, 8'h5A);
      bus_read(A_UART, rd);
      chk("rx_5a_cleared", rd, 8'h00);
      uart_send(8'hC3, 1'b0);
      bus_read(A_UART, rd);
      chk("rx_bad_stop", rd, 8'h00);
      uart_send(8'h11, 1'b1);
      uart_send(8'h22, 1'b1);
      bus_read(A_UART, rd);
      chk("rx_overwrite", rd, 8'h22);
      bus_read(A_UART, rd);
      chk("rx_overwrite_cleared", rd, 8'h00);
      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom);
         st = 1'($urandom_range(0, 1));
         uart_send(rb, st);
         bus_read(A_UART, rd);
         chk($sformatf("rx_rand_%0d", i), rd, st ? rb : 8'h00);
      end

      // halt
      chk("led_before_halt", led, 0);
      bus_write(A_HALT, 8'($urandom));
      chk("halt_led_next", led, 1);
      repeat (5) cyc();
      chk("halt_led_sticky", led, 1);
      bus_read(A_HALT, rd);
      chk("halt_read_zero", rd, 8'h00);

      // reset in the middle of TX and with an unread RX byte
      uart_send(8'h77, 1'b1);
      bus_write(A_UART, 8'h55);
      bus_write(A_UART, 8'h66);
      repeat (10) cyc();
      chk("midrst_tx_busy", Tx, 8'h55 >> 3 & 1);
      mon_en = 1'b0;
      btnC   = 1'b1;
      repeat (3) cyc();
      chk("midrst_tx", Tx, 1);
      chk("midrst_led", led, 0);
      chk("midrst_full", bus.io_buffer_full, 0);
      repeat (5) cyc();
      btnC = 1'b0;
      repeat (60) cyc();
      txq.delete();
      mon_en = 1'b1;
      bus_read(A_UART, rd);
      chk("midrst_rx_cleared", rd, 8'h00);
      bus_write(A_UART, 8'h99);
      wait_q(1, 60);
      repeat (60) cyc();
      chk("midrst_fifo_empty", txq.size(), 1);
      if (txq.size() > 0) begin
         ent = txq.pop_front();
         chk("midrst_tx_99", ent, {1'b0, 8'h99});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
